// File: rtl/mem_rw_sequencer.sv
// rtl/mem_rw_sequencer.sv - four-phase NCL sequencer for the dual-rail memory RW mux
// Arbitrates fetch/data requesters and runs DATA/NULL wavefronts, latching the resolved RW.
module mem_rw_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic fetch_done,
  output logic data_done,
  output logic rw_value,
  output logic busy,
  output logic err,
  input  logic err_clr,
  output logic ph0_t,
  output logic ph0_f,
  output logic mi_t,
  output logic mi_f,
  input  logic rw_t,
  input  logic rw_f
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL, S_ERROR} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] t_sync, f_sync;
  logic rw_s_t, rw_s_f, rw_valid, rw_null, rw_illegal;

  logic tok_ph0, tok_mi, side_data, rr_data;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] to_cnt;

  logic fetch_eff, data_eff, hold_ok, timed_out, awaited;
  logic take_grant, grant_is_data, rr_flip, latch_rw, done_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_sync <= '0;
      f_sync <= '0;
    end else begin
      t_sync <= {t_sync[SYNC_STAGES-2:0], rw_t};
      f_sync <= {f_sync[SYNC_STAGES-2:0], rw_f};
    end
  end

  assign rw_s_t     = t_sync[SYNC_STAGES-1];
  assign rw_s_f     = f_sync[SYNC_STAGES-1];
  assign rw_valid   = rw_s_t ^ rw_s_f;
  assign rw_null    = ~rw_s_t & ~rw_s_f;
  assign rw_illegal = rw_s_t & rw_s_f;

  // A side whose done is pulsing this cycle is not re-granted until the next cycle.
  assign fetch_eff = fetch_req & ~fetch_done;
  assign data_eff  = data_req & ~data_done;
  assign hold_ok   = hold_cnt >= HW'(MIN_HOLD - 1);
  assign timed_out = to_cnt >= CW'(TIMEOUT - 1);
  assign awaited   = (state == S_DATA) ? rw_valid : rw_null;

  always_comb begin
    state_n       = state;
    take_grant    = 1'b0;
    grant_is_data = 1'b0;
    rr_flip       = 1'b0;
    latch_rw      = 1'b0;
    done_pulse    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_eff || data_eff) begin
          take_grant = 1'b1;
          state_n    = S_DATA;
          if (fetch_eff && data_eff) begin
            grant_is_data = rr_data;
            rr_flip       = 1'b1;
          end else begin
            grant_is_data = data_eff;
          end
        end
      end
      S_DATA: begin
        if (rw_illegal || timed_out) begin
          state_n = S_ERROR;
        end else if (rw_valid && hold_ok) begin
          latch_rw = 1'b1;
          state_n  = S_NULL;
        end
      end
      S_NULL: begin
        if (rw_illegal || timed_out) begin
          state_n = S_ERROR;
        end else if (rw_null && hold_ok) begin
          done_pulse = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: begin
        if (err_clr && rw_null) state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tok_ph0    <= 1'b0;
      tok_mi     <= 1'b0;
      side_data  <= 1'b0;
      rr_data    <= 1'b0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      rw_value   <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_done <= done_pulse & ~side_data;
      data_done  <= done_pulse & side_data;
      if (take_grant) begin
        tok_ph0   <= grant_is_data;
        tok_mi    <= grant_is_data & data_we;
        side_data <= grant_is_data;
      end
      if (rr_flip) rr_data <= ~grant_is_data;
      if (latch_rw) rw_value <= rw_s_t;
      // Hold counts consecutive cycles the awaited completion is seen, so the
      // wavefront lasts SYNC_STAGES + MIN_HOLD cycles even with a zero-delay mux.
      if (state_n != state || !awaited) begin
        hold_cnt <= '0;
      end else if (hold_cnt < HW'(MIN_HOLD - 1)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      if (state_n != state) begin
        to_cnt <= '0;
      end else if (to_cnt != CW'(TIMEOUT)) begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

  // Rails are decoded from state so an asynchronous reset forces NULL at once.
  assign ph0_t = (state == S_DATA) & tok_ph0;
  assign ph0_f = (state == S_DATA) & ~tok_ph0;
  assign mi_t  = (state == S_DATA) & tok_mi;
  assign mi_f  = (state == S_DATA) & ~tok_mi;
  assign busy  = state != S_IDLE;
  assign err   = state == S_ERROR;

endmodule

// File: tb/tb_mem_rw_sequencer.sv
// tb/tb_mem_rw_sequencer.sv - self-checking bench for mem_rw_sequencer
module tb_mem_rw_sequencer;

  logic clk = 1'b0;
  logic rst_n, fetch_req, data_req, data_we, err_clr, rw_t, rw_f;
  logic fetch_done, data_done, rw_value, busy, err;
  logic ph0_t, ph0_f, mi_t, mi_f;

  int checks = 0;
  int errors = 0;

  mem_rw_sequencer #(.SYNC_STAGES(2), .MIN_HOLD(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
    .fetch_done(fetch_done), .data_done(data_done), .rw_value(rw_value), .busy(busy), .err(err),
    .err_clr(err_clr), .ph0_t(ph0_t), .ph0_f(ph0_f), .mi_t(mi_t), .mi_f(mi_f),
    .rw_t(rw_t), .rw_f(rw_f)
  );

  always #5 clk = ~clk;

  // Mux model: RW = PH0 ? ~MI : 1, only once both input pairs carry DATA.
  logic       mux_dvalid, mux_val;
  logic [1:0] mux_comb, mux_sel;
  logic [1:0] pipe [16];
  int         mux_delay = 0;
  bit         mode_dead = 1'b0;
  bit         mode_illegal = 1'b0;

  assign mux_dvalid = (ph0_t ^ ph0_f) & (mi_t ^ mi_f);
  assign mux_val    = ph0_t ? mi_f : 1'b1;
  assign mux_comb   = {mux_dvalid & mux_val, mux_dvalid & ~mux_val};
  assign mux_sel    = (mux_delay == 0) ? mux_comb : pipe[mux_delay-1];
  assign rw_t       = mode_illegal | (~mode_dead & mux_sel[1]);
  assign rw_f       = mode_illegal | (~mode_dead & mux_sel[0]);

  always @(posedge clk) begin
    pipe[0] <= mux_comb;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct {bit is_data; bit rw;} exp_t;
  exp_t sb[$];

  typedef struct {bit f; bit d; bit we; bit exp_data; bit [3:0] tok; bit rw;} vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer and NULL-separation monitor, sampled on the falling edge.
  bit   prev_data = 1'b0;
  bit   prev_rw_null = 1'b1;
  exp_t e;
  always @(negedge clk) begin
    if (fetch_done || data_done) begin
      check("done_onehot", 32'(fetch_done & data_done), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got fetch=%0b data=%0b expected none", fetch_done, data_done);
      end else begin
        e = sb.pop_front();
        check("done_side", 32'(data_done), 32'(e.is_data));
        check("done_rw_value", 32'(rw_value), 32'(e.rw));
      end
    end
    if ((ph0_t | ph0_f) && !prev_data) check("null_before_data", 32'(prev_rw_null), 1);
    prev_data    = ph0_t | ph0_f;
    prev_rw_null = ~rw_t & ~rw_f;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit f, input bit d, input bit we, input bit exp_data,
                         input bit [3:0] tok, input bit rw, input int exp_lat, input string tag);
    int lat;
    bit saw_null;
    sb.push_back('{exp_data, rw});
    fetch_req = f;
    data_req  = d;
    data_we   = we;
    tick();
    check({tag, "_token"}, 32'({ph0_t, ph0_f, mi_t, mi_f}), 32'(tok));
    lat = 1;
    saw_null = 1'b0;
    while (!(fetch_done || data_done) && lat < 300) begin
      tick();
      lat++;
      if (busy && !(ph0_t | ph0_f | mi_t | mi_f)) saw_null = 1'b1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_null_phase"}, 32'(saw_null), 1);
    check({tag, "_rw_value"}, 32'(rw_value), 32'(rw));
    fetch_req = 1'b0;
    data_req  = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b1};

    rst_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'({ph0_t, ph0_f, mi_t, mi_f, fetch_done, data_done, rw_value, busy, err}), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].f, vecs[i].d, vecs[i].we, vecs[i].exp_data, vecs[i].tok, vecs[i].rw, 9,
              $sformatf("vec%0d", i));

    // Contention: both held, grants alternate F,D,F,D back to back.
    sb.push_back('{1'b0, 1'b1});
    sb.push_back('{1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1});
    sb.push_back('{1'b1, 1'b0});
    fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick(); n++; end while (!(fetch_done || data_done) && n < 100);
      check($sformatf("contention_lat%0d", k), n, 9);
      if (k == 3) begin fetch_req = 1'b0; data_req = 1'b0; end
    end
    tick();

    // Slow mux: 10 cycles of extra delay in each phase.
    mux_delay = 10;
    repeat (12) tick();
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 29, "slow");
    check("slow_no_err", 32'(err), 0);
    mux_delay = 0;
    repeat (2) tick();

    // Timeout: mux never answers.
    mode_dead = 1'b1;
    fetch_req = 1'b1;
    tick();
    check("timeout_data_entry", 32'({ph0_t, ph0_f}), 32'(2'b01));
    n = 0;
    while (!err && n < 200) begin tick(); n++; end
    check("timeout_cycles", n, 64);
    fetch_req = 1'b0;
    check("timeout_outputs_null", 32'({ph0_t, ph0_f, mi_t, mi_f}), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("timeout_clr", 32'({err, busy}), 0);
    mode_dead = 1'b0;
    tick();

    // Illegal RW during DRIVE_DATA.
    fetch_req = 1'b1;
    tick();
    mode_illegal = 1'b1;
    n = 0;
    while (!err && n < 20) begin tick(); n++; end
    check("illegal_cycles", n, 3);
    fetch_req = 1'b0;
    err_clr = 1'b1;
    repeat (4) tick();
    check("illegal_clr_ignored", 32'(err), 1);
    mode_illegal = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("illegal_clr_cycles", n, 3);
    check("illegal_recovered", 32'({err, busy}), 0);
    err_clr = 1'b0;
    tick();

    // Reset mid-DRIVE_DATA; the pointer currently names data.
    data_req = 1'b1; data_we = 1'b0;
    tick();
    check("rst_pre_token", 32'({ph0_t, ph0_f, mi_t, mi_f}), 32'(4'b1001));
    #2 rst_n = 1'b0;
    #1 check("rst_async_null", 32'({ph0_t, ph0_f, mi_t, mi_f, busy}), 0);
    data_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 9, "rr_after_reset");
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b1, 9, "rr_flip");

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
